hazard_unit: RTL and testbench

- Consumes the per-instruction control bits produced by the decode stage (reg_wren, mem_to_reg, mem_wr, branch, dst_reg_sel) and tracks every in-flight register writer.
- Tracks writers in a 3-entry scoreboard covering the EX, MEM and WB stages.
- Generates stall, bubble and flush controls for the 5-stage pipeline.
- Keeps a saturating stall-cycle counter.
- Sits between ID and the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_unit.sv | 138 +++++++++++++
 tb/tb_hazard_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - ID-stage hazard detection: writer scoreboard, stall/bubble/flush, stall counter
//
// Purpose: tracks in-flight register writers in EX/MEM/WB and decides, for the
// instruction currently in ID, whether the front end must stall (hold PC and
// IF/ID, bubble ID/EX) or whether a taken branch squashes IF/ID.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_rs/id_rt/id_rd   register fields of the ID instruction
//   id_uses_rs/rt       instruction reads rs / rt
//   id_reg_wren         decoded register write enable
//   id_mem_to_reg       decoded load
//   id_mem_wr           decoded store
//   id_branch           decoded branch
//   id_dst_reg_sel      0: destination rt, 1: destination rd
//   id_br_taken         branch resolved taken (meaningful with id_branch)
//   pc_stall            hold PC
//   ifid_stall          hold IF/ID
//   idex_bubble         load a NOP into ID/EX
//   ifid_flush          squash IF/ID on the next edge
//   stall_cnt           saturating count of stall cycles

module hazard_unit #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic [3:0]       id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_wren,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_wr,
  input  logic             id_branch,
  input  logic             id_dst_reg_sel,
  input  logic             id_br_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  // Scoreboard entries, one per downstream stage.
  logic       ex_v, ex_ld, mem_v, mem_ld, wb_v, wb_ld;
  logic [3:0] ex_dst, mem_dst, wb_dst;

  logic [3:0] id_dst;
  logic       writer;
  logic       need_rs, need_rt;
  logic       ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic       data_hz, br_hz, stall;

  // A store never writes the register file; its data register is covered by
  // id_uses_rt, so the store flag itself has no effect on hazard detection.
  logic unused_store;
  assign unused_store = id_mem_wr;

  assign id_dst  = id_dst_reg_sel ? id_rd : id_rt;
  assign writer  = id_valid & id_reg_wren;
  assign need_rs = id_valid & id_uses_rs;
  assign need_rt = id_valid & id_uses_rt;

  // Register 0 is hardwired, so it never matches.
  assign ex_rs  = ex_v  & (ex_dst  == id_rs) & (id_rs != 4'd0);
  assign ex_rt  = ex_v  & (ex_dst  == id_rt) & (id_rt != 4'd0);
  assign mem_rs = mem_v & (mem_dst == id_rs) & (id_rs != 4'd0);
  assign mem_rt = mem_v & (mem_dst == id_rt) & (id_rt != 4'd0);
  assign wb_rs  = wb_v  & (wb_dst  == id_rs) & (id_rs != 4'd0);
  assign wb_rt  = wb_v  & (wb_dst  == id_rt) & (id_rt != 4'd0);

  always_comb begin
    data_hz = 1'b0;
    if (FWD_EN) begin
      // Forwarding covers everything except a load still in EX.
      data_hz = ex_ld & ((ex_rs & need_rs) | (ex_rt & need_rt));
    end else begin
      // No bypass at all, including write-before-read in WB.
      data_hz = ((ex_rs | mem_rs | wb_rs) & need_rs) |
                ((ex_rt | mem_rt | wb_rt) & need_rt);
    end
  end

  // Branches compare in ID, so an ALU result still in EX or a load in MEM
  // cannot be forwarded early enough.
  assign br_hz = id_branch & need_rs & (ex_rs | (mem_rs & mem_ld));

  // Gating with rst drops a stall in the same cycle reset is asserted.
  assign stall       = ~rst & (data_hz | br_hz);
  assign pc_stall    = stall;
  assign ifid_stall  = stall;
  assign idex_bubble = stall;
  assign ifid_flush  = ~rst & id_valid & id_branch & id_br_taken & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v    <= 1'b0;
      ex_ld   <= 1'b0;
      ex_dst  <= 4'd0;
      mem_v   <= 1'b0;
      mem_ld  <= 1'b0;
      mem_dst <= 4'd0;
      wb_v    <= 1'b0;
      wb_ld   <= 1'b0;
      wb_dst  <= 4'd0;
    end else begin
      wb_v    <= mem_v;
      wb_ld   <= mem_ld;
      wb_dst  <= mem_dst;
      mem_v   <= ex_v;
      mem_ld  <= ex_ld;
      mem_dst <= ex_dst;
      if (stall) begin
        ex_v   <= 1'b0;
        ex_ld  <= 1'b0;
        ex_dst <= 4'd0;
      end else begin
        ex_v   <= writer;
        ex_ld  <= id_mem_to_reg;
        ex_dst <= id_dst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed model-checked bench for hazard_unit

module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_reg_wren, id_mem_to_reg, id_mem_wr;
  logic       id_branch, id_dst_reg_sel, id_br_taken;

  logic [2:0]  pc_s, if_s, bub, fl;
  logic [15:0] c0, c1;
  logic [3:0]  c2;

  int nchecks = 0;
  int nerrors = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  // dut 0: forwarding, 16-bit counter; dut 1: no forwarding; dut 2: forwarding, 4-bit counter
  hazard_unit #(.FWD_EN(1'b1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_wren(id_reg_wren),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_wr(id_mem_wr), .id_branch(id_branch),
    .id_dst_reg_sel(id_dst_reg_sel), .id_br_taken(id_br_taken),
    .pc_stall(pc_s[0]), .ifid_stall(if_s[0]), .idex_bubble(bub[0]), .ifid_flush(fl[0]),
    .stall_cnt(c0));

  hazard_unit #(.FWD_EN(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_wren(id_reg_wren),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_wr(id_mem_wr), .id_branch(id_branch),
    .id_dst_reg_sel(id_dst_reg_sel), .id_br_taken(id_br_taken),
    .pc_stall(pc_s[1]), .ifid_stall(if_s[1]), .idex_bubble(bub[1]), .ifid_flush(fl[1]),
    .stall_cnt(c1));

  hazard_unit #(.FWD_EN(1'b1), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_wren(id_reg_wren),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_wr(id_mem_wr), .id_branch(id_branch),
    .id_dst_reg_sel(id_dst_reg_sel), .id_br_taken(id_br_taken),
    .pc_stall(pc_s[2]), .ifid_stall(if_s[2]), .idex_bubble(bub[2]), .ifid_flush(fl[2]),
    .stall_cnt(c2));

  // Reference model: for each dut, the write effects of the last three
  // instructions that left ID (index 0 = youngest), plus a stall tally.
  typedef struct packed {
    bit       v;
    bit       ld;
    bit [3:0] dst;
  } ent_t;

  ent_t        inflight [3][3];
  int unsigned mcnt [3];
  bit          fwd  [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned cmax [3] = '{65535, 65535, 15};

  initial begin
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      for (int k = 0; k < 3; k++) inflight[i][k] = '0;
    end
  end

  function automatic bit writes(int i, int age, logic [3:0] r);
    return inflight[i][age].v && inflight[i][age].dst == r && r != 4'd0;
  endfunction

  function automatic bit m_stall(int i);
    bit nrs, nrt, hz;
    if (rst) return 1'b0;
    nrs = id_valid && id_uses_rs;
    nrt = id_valid && id_uses_rt;
    hz  = 1'b0;
    if (fwd[i]) begin
      if (inflight[i][0].ld && ((nrs && writes(i, 0, id_rs)) || (nrt && writes(i, 0, id_rt))))
        hz = 1'b1;
    end else begin
      for (int a = 0; a < 3; a++)
        if ((nrs && writes(i, a, id_rs)) || (nrt && writes(i, a, id_rt))) hz = 1'b1;
    end
    if (id_branch && nrs && (writes(i, 0, id_rs) || (writes(i, 1, id_rs) && inflight[i][1].ld)))
      hz = 1'b1;
    return hz;
  endfunction

  function automatic int m_cnt_dut(int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mcnt[i] <= 0;
        for (int k = 0; k < 3; k++) inflight[i][k] <= '0;
      end else begin
        bit s;
        s = m_stall(i);
        inflight[i][2] <= inflight[i][1];
        inflight[i][1] <= inflight[i][0];
        if (s) inflight[i][0] <= '0;
        else inflight[i][0] <= '{v: id_valid && id_reg_wren, ld: id_mem_to_reg,
                                 dst: (id_dst_reg_sel ? id_rd : id_rt)};
        if (s && mcnt[i] < cmax[i]) mcnt[i] <= mcnt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        bit s, f;
        s = m_stall(i);
        f = !rst && id_valid && id_branch && id_br_taken && !s;
        chk($sformatf("pc_stall[%0d]", i), int'(pc_s[i]), int'(s));
        chk($sformatf("ifid_stall[%0d]", i), int'(if_s[i]), int'(s));
        chk($sformatf("idex_bubble[%0d]", i), int'(bub[i]), int'(s));
        chk($sformatf("ifid_flush[%0d]", i), int'(fl[i]), int'(f));
        chk($sformatf("stall_cnt[%0d]", i), m_cnt_dut(i), int'(mcnt[i]));
      end
    end
  end

  task automatic drive(bit v, logic [3:0] rs, logic [3:0] rt, logic [3:0] rd,
                       bit urs, bit urt, bit wren, bit m2r, bit mw, bit br, bit dsel, bit tk);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_reg_wren = wren; id_mem_to_reg = m2r;
    id_mem_wr = mw; id_branch = br; id_dst_reg_sel = dsel; id_br_taken = tk;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lw(logic [3:0] dst, logic [3:0] base);
    drive(1, base, dst, 0, 1, 0, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic alu(logic [3:0] rd, logic [3:0] rs, logic [3:0] rt);
    drive(1, rs, rt, rd, 1, 1, 1, 0, 0, 0, 1, 0);
  endtask

  task automatic br(logic [3:0] rs, bit tk);
    drive(1, rs, 0, 0, 1, 0, 0, 0, 0, 1, 0, tk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    nop();
    tick();
    cmp_en = 1'b1;

    // reset holds every output low even with a dependent pair in ID
    lw(3, 1);
    @(negedge clk);
    chk("rst_stall", int'(pc_s[0]), 0);
    chk("rst_cnt", int'(c0), 0);
    tick();
    alu(5, 3, 4);
    @(negedge clk);
    chk("rst_stall2", int'(pc_s[1]), 0);
    chk("rst_bubble", int'(bub[0]), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release", int'(pc_s[0]), 0);
    chk("rst_release_nf", int'(pc_s[1]), 0);
    tick();

    // load-use
    do_reset();
    lw(3, 1);
    @(negedge clk);
    chk("lu_first", int'(pc_s[0]), 0);
    tick();
    alu(5, 3, 4);
    @(negedge clk);
    chk("lu_stall", int'(pc_s[0]), 1);
    chk("lu_bubble", int'(bub[0]), 1);
    chk("lu_ifid", int'(if_s[0]), 1);
    tick();
    @(negedge clk);
    chk("lu_after", int'(pc_s[0]), 0);
    chk("lu_cnt", int'(c0), 1);
    tick();
    nop();
    repeat (3) tick();

    // ALU back-to-back
    do_reset();
    alu(2, 1, 1);
    tick();
    alu(6, 2, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alu_fwd", int'(pc_s[0]), 0);
      chk("alu_nofwd", int'(pc_s[1]), (k < 3) ? 1 : 0);
      tick();
    end
    @(negedge clk);
    chk("alu_cnt_nofwd", int'(c1), 3);
    chk("alu_cnt_fwd", int'(c0), 0);
    tick();

    // register 0
    do_reset();
    lw(0, 1);
    tick();
    alu(5, 0, 0);
    @(negedge clk);
    chk("r0_fwd", int'(pc_s[0]), 0);
    chk("r0_nofwd", int'(pc_s[1]), 0);
    tick();
    nop();
    tick();

    // ALU then branch on its result
    do_reset();
    alu(7, 1, 1);
    tick();
    br(7, 1);
    @(negedge clk);
    chk("br_alu_stall", int'(pc_s[0]), 1);
    chk("br_alu_noflush", int'(fl[0]), 0);
    tick();
    @(negedge clk);
    chk("br_alu_go", int'(pc_s[0]), 0);
    chk("br_alu_flush", int'(fl[0]), 1);
    tick();
    nop();
    @(negedge clk);
    chk("br_alu_flush_once", int'(fl[0]), 0);
    tick();

    // load then branch on its result
    do_reset();
    lw(7, 1);
    tick();
    br(7, 1);
    @(negedge clk);
    chk("br_ld_stall1", int'(pc_s[0]), 1);
    tick();
    @(negedge clk);
    chk("br_ld_stall2", int'(pc_s[0]), 1);
    chk("br_ld_noflush", int'(fl[0]), 0);
    tick();
    @(negedge clk);
    chk("br_ld_go", int'(pc_s[0]), 0);
    chk("br_ld_flush", int'(fl[0]), 1);
    chk("br_ld_cnt", int'(c0), 2);
    tick();
    nop();
    tick();

    // saturation: 20 load-use stalls
    do_reset();
    repeat (20) begin
      lw(3, 1);
      tick();
      alu(5, 3, 3);
      tick();
      tick();
    end
    nop();
    @(negedge clk);
    chk("sat_cnt4", int'(c2), 15);
    chk("sat_cnt16", int'(c0), 20);
    tick();
    @(negedge clk);
    chk("sat_hold", int'(c2), 15);
    tick();

    // randomized traffic, including stores and occasional reset
    repeat (3000) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 7) != 0,
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    rst = 1'b0;
    nop();
    tick();
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
